// File: rtl/udma_l2_responder.sv
// L2 memory-side responder for the uDMA ro/wo ports: one shared word array behind two
// independent req/gnt/rvalid targets, each with a programmable grant stall.
module udma_l2_responder #(
  parameter int unsigned L2_DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR     = 32'h1C00_0000,
  parameter int unsigned GNT_STALL     = 0
) (
  input  logic                       sys_clk_i,
  input  logic                       sys_rst_i,
  input  logic                       ro_req_i,
  input  logic                       ro_wen_i,
  output logic                       ro_gnt_o,
  input  logic [31:0]                ro_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0] ro_be_i,
  input  logic [L2_DATA_WIDTH-1:0]   ro_wdata_i,
  output logic                       ro_rvalid_o,
  output logic [L2_DATA_WIDTH-1:0]   ro_rdata_o,
  input  logic                       wo_req_i,
  input  logic                       wo_wen_i,
  output logic                       wo_gnt_o,
  input  logic [31:0]                wo_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0] wo_be_i,
  input  logic [L2_DATA_WIDTH-1:0]   wo_wdata_i,
  output logic                       wo_rvalid_o,
  output logic [L2_DATA_WIDTH-1:0]   wo_rdata_o,
  output logic                       err_o
);

  localparam int unsigned DW    = L2_DATA_WIDTH;
  localparam int unsigned BE_W  = DW / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam logic [3:0]  STALL_CYC = 4'(GNT_STALL);

  function automatic logic [DW-1:0] fill_bad_word();
    logic [31:0]   pat;
    logic [DW-1:0] w;
    pat = 32'hDEAD_BEEF;
    w   = '0;
    for (int i = 0; i < int'(DW); i++) w[i] = pat[i % 32];
    return w;
  endfunction

  localparam logic [DW-1:0] BAD_WORD = fill_bad_word();

  // Port 0 is ro, port 1 is wo throughout.
  logic [1:0]                 req, wen, gnt, oob;
  logic [1:0][31:0]           addr, word_off;
  logic [1:0][BE_W-1:0]       be;
  logic [1:0][DW-1:0]         wdata;
  logic [1:0][IDX_W-1:0]      idx;
  logic [1:0][3:0]            cnt_q, cnt_d;
  logic [1:0]                 rvalid_q;
  logic [1:0][DW-1:0]         rdata_q, rdata_d;
  logic                       err_q, err_d;
  logic [DW-1:0]              mem_q [MEM_WORDS];

  assign req   = {wo_req_i, ro_req_i};
  assign wen   = {wo_wen_i, ro_wen_i};
  assign addr  = {wo_addr_i, ro_addr_i};
  assign be    = {wo_be_i, ro_be_i};
  assign wdata = {wo_wdata_i, ro_wdata_i};

  // NOTE: every variable driven here gets a default before any condition, so no latch is inferred.
  always_comb begin
    err_d = err_q;
    for (int p = 0; p < 2; p++) begin
      word_off[p] = (addr[p] - BASE_ADDR) >> OFF_W;
      oob[p]      = (word_off[p] >= 32'(MEM_WORDS));
      idx[p]      = word_off[p][IDX_W-1:0];
      gnt[p]      = req[p] && (cnt_q[p] == STALL_CYC);
      cnt_d[p]    = (req[p] && !gnt[p]) ? cnt_q[p] + 4'd1 : 4'd0;
      rdata_d[p]  = rdata_q[p];
      if (gnt[p]) begin
        if (oob[p]) begin
          rdata_d[p] = BAD_WORD;
          err_d      = 1'b1;
        end else if (!wen[p]) begin
          rdata_d[p] = '0;
        end else begin
          rdata_d[p] = mem_q[idx[p]];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so reads in the same edge see pre-write data.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      cnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rvalid_q <= gnt;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // NOTE: the array is deliberately not reset; its contents must survive sys_rst_i.
  // The wo port is visited last, so on bytes enabled by both ports its data lands.
  always_ff @(posedge sys_clk_i) begin
    for (int p = 0; p < 2; p++) begin
      if (gnt[p] && !wen[p] && !oob[p]) begin
        for (int b = 0; b < int'(BE_W); b++) begin
          if (be[p][b]) mem_q[idx[p]][8*b +: 8] <= wdata[p][8*b +: 8];
        end
      end
    end
  end

  assign ro_gnt_o    = gnt[0];
  assign wo_gnt_o    = gnt[1];
  assign ro_rvalid_o = rvalid_q[0];
  assign wo_rvalid_o = rvalid_q[1];
  assign ro_rdata_o  = rdata_q[0];
  assign wo_rdata_o  = rdata_q[1];
  assign err_o       = err_q;

endmodule

// File: tb/tb_udma_l2_responder.sv
// Self-checking bench for udma_l2_responder: a zero-stall instance driven through a
// response scoreboard, and a GNT_STALL=3 instance checked for grant timing.
module tb_udma_l2_responder;

  localparam int          MW   = 1024;
  localparam logic [31:0] BASE = 32'h1C00_0000;

  typedef struct packed {
    logic        req;
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        ro_req, ro_wen, ro_gnt, ro_rvalid;
  logic [31:0] ro_addr, ro_wdata, ro_rdata;
  logic [3:0]  ro_be;
  logic        wo_req, wo_wen, wo_gnt, wo_rvalid;
  logic [31:0] wo_addr, wo_wdata, wo_rdata;
  logic [3:0]  wo_be;
  logic        err;

  logic        s_req, s_wen, s_gnt, s_rvalid;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  logic        s_wo_req, s_wo_wen, s_wo_gnt, s_wo_rvalid;
  logic [31:0] s_wo_addr, s_wo_wdata, s_wo_rdata;
  logic [3:0]  s_wo_be;
  logic        s_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] ro_q[$];
  logic [31:0] wo_q[$];
  logic [31:0] model [MW];

  udma_l2_responder #(.L2_DATA_WIDTH(32), .MEM_WORDS(MW), .BASE_ADDR(BASE), .GNT_STALL(0)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .ro_req_i(ro_req), .ro_wen_i(ro_wen), .ro_gnt_o(ro_gnt), .ro_addr_i(ro_addr),
    .ro_be_i(ro_be), .ro_wdata_i(ro_wdata), .ro_rvalid_o(ro_rvalid), .ro_rdata_o(ro_rdata),
    .wo_req_i(wo_req), .wo_wen_i(wo_wen), .wo_gnt_o(wo_gnt), .wo_addr_i(wo_addr),
    .wo_be_i(wo_be), .wo_wdata_i(wo_wdata), .wo_rvalid_o(wo_rvalid), .wo_rdata_o(wo_rdata),
    .err_o(err)
  );

  udma_l2_responder #(.L2_DATA_WIDTH(32), .MEM_WORDS(MW), .BASE_ADDR(BASE), .GNT_STALL(3)) dut_s (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .ro_req_i(s_req), .ro_wen_i(s_wen), .ro_gnt_o(s_gnt), .ro_addr_i(s_addr),
    .ro_be_i(s_be), .ro_wdata_i(s_wdata), .ro_rvalid_o(s_rvalid), .ro_rdata_o(s_rdata),
    .wo_req_i(s_wo_req), .wo_wen_i(s_wo_wen), .wo_gnt_o(s_wo_gnt), .wo_addr_i(s_wo_addr),
    .wo_be_i(s_wo_be), .wo_wdata_i(s_wo_wdata), .wo_rvalid_o(s_wo_rvalid), .wo_rdata_o(s_wo_rdata),
    .err_o(s_err)
  );

  // Scoreboard: every rvalid must match the oldest prediction for its port.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (ro_rvalid === 1'b1) begin
      checks++;
      if (ro_q.size() == 0) begin
        errors++;
        $display("FAIL ro_unexpected_rvalid got rdata=%h expected no response", ro_rdata);
      end else begin
        exp = ro_q.pop_front();
        if (ro_rdata !== exp) begin
          errors++;
          $display("FAIL ro_rdata got=%h expected=%h", ro_rdata, exp);
        end
      end
    end
    if (wo_rvalid === 1'b1) begin
      checks++;
      if (wo_q.size() == 0) begin
        errors++;
        $display("FAIL wo_unexpected_rvalid got rdata=%h expected no response", wo_rdata);
      end else begin
        exp = wo_q.pop_front();
        if (wo_rdata !== exp) begin
          errors++;
          $display("FAIL wo_rdata got=%h expected=%h", wo_rdata, exp);
        end
      end
    end
  end

  function automatic txn_t nop();
    return '{req: 1'b0, wen: 1'b1, addr: 32'h0, be: 4'h0, wdata: 32'h0};
  endfunction
  function automatic txn_t rd(input logic [31:0] a);
    return '{req: 1'b1, wen: 1'b1, addr: a, be: 4'hF, wdata: 32'h0};
  endfunction
  function automatic txn_t wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    return '{req: 1'b1, wen: 1'b0, addr: a, be: b, wdata: d};
  endfunction

  function automatic logic [31:0] resp(input txn_t t);
    logic [31:0] w;
    w = (t.addr - BASE) >> 2;
    if (w >= MW) return 32'hDEAD_BEEF;
    if (!t.wen) return 32'h0;
    return model[w];
  endfunction

  task automatic commit(input txn_t t);
    logic [31:0] w;
    w = (t.addr - BASE) >> 2;
    if (!t.wen && w < MW)
      for (int b = 0; b < 4; b++) if (t.be[b]) model[w][8*b +: 8] = t.wdata[8*b +: 8];
  endtask

  // Drive one cycle on both ports; requests stay asserted until idle() or the next run().
  task automatic run(input txn_t r, input txn_t w);
    @(posedge clk); #1;
    ro_req = r.req; ro_wen = r.wen; ro_addr = r.addr; ro_be = r.be; ro_wdata = r.wdata;
    wo_req = w.req; wo_wen = w.wen; wo_addr = w.addr; wo_be = w.be; wo_wdata = w.wdata;
    @(negedge clk);
    if (r.req) begin
      checks++;
      if (ro_gnt !== 1'b1) begin errors++; $display("FAIL ro_gnt_same_cycle got=%b expected=1", ro_gnt); end
      ro_q.push_back(resp(r));
    end
    if (w.req) begin
      checks++;
      if (wo_gnt !== 1'b1) begin errors++; $display("FAIL wo_gnt_same_cycle got=%b expected=1", wo_gnt); end
      wo_q.push_back(resp(w));
    end
    if (r.req) commit(r);
    if (w.req) commit(w);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    ro_req = 1'b0; wo_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ro_req = 0; ro_wen = 1; ro_addr = 0; ro_be = 0; ro_wdata = 0;
    wo_req = 0; wo_wen = 1; wo_addr = 0; wo_be = 0; wo_wdata = 0;
    s_req = 0; s_wen = 1; s_addr = 0; s_be = 0; s_wdata = 0;
    s_wo_req = 0; s_wo_wen = 1; s_wo_addr = 0; s_wo_be = 0; s_wo_wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ro_rvalid, wo_rvalid, ro_gnt, wo_gnt, err, s_err, s_rvalid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b expected=0000000",
               {ro_rvalid, wo_rvalid, ro_gnt, wo_gnt, err, s_err, s_rvalid});
    end
    checks++;
    if ({ro_rdata, wo_rdata, s_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_rdata got=%h %h %h expected=0", ro_rdata, wo_rdata, s_rdata);
    end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_basic();
    run(nop(), wr(BASE, 4'hF, 32'hA5A5_0001));
    run(rd(BASE), nop());
    idle();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL basic_err got=%b expected=0", err); end
  endtask

  task automatic test_partial();
    run(nop(), wr(BASE + 4, 4'hF, 32'h1122_3344));
    run(wr(BASE + 4, 4'b0010, 32'h0000_FF00), nop());
    run(nop(), wr(BASE + 4, 4'b0000, 32'hFFFF_FFFF));
    run(rd(BASE + 4), nop());
    idle();
    @(negedge clk);
    checks++;
    if (ro_rvalid !== 1'b0 || ro_rdata !== 32'h1122_FF44) begin
      errors++;
      $display("FAIL partial_hold got rvalid=%b rdata=%h expected rvalid=0 rdata=1122ff44", ro_rvalid, ro_rdata);
    end
  endtask

  task automatic test_back_to_back();
    run(wr(BASE + 8, 4'hF, 32'h0), wr(BASE + 12, 4'hF, 32'h0BAD_CAFE));
    run(wr(BASE + 8, 4'b0011, 32'h1111_1111), wr(BASE + 8, 4'b0110, 32'h2222_2222));
    run(rd(BASE + 8), rd(BASE + 12));
    run(rd(BASE + 12), rd(BASE));
    run(rd(BASE + 4), rd(BASE + 8));
    idle();
    checks++;
    if (model[2] !== 32'h0022_2211) begin
      errors++;
      $display("FAIL merge_model got=%h expected=00222211", model[2]);
    end
  endtask

  task automatic test_same_word();
    run(nop(), wr(BASE + 20, 4'hF, 32'h5555_5555));
    run(rd(BASE + 20), wr(BASE + 20, 4'hF, 32'hCAFE_F00D));
    run(rd(BASE + 20), nop());
    idle();
  endtask

  task automatic test_oob();
    run(rd(BASE + MW * 4), nop());
    idle();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL oob_err_set got=%b expected=1", err); end
    run(nop(), wr(BASE + MW * 4, 4'hF, 32'hBADB_AD00));
    run(rd(BASE - 4), rd(BASE));
    run(rd(BASE + 4), nop());
    idle();
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL oob_err_sticky got=%b expected=1", err); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    ro_req = 1'b1; ro_wen = 1'b1; ro_addr = BASE; ro_be = 4'hF;
    @(negedge clk);
    checks++;
    if (ro_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt got=%b expected=1", ro_gnt); end
    rst = 1'b1;
    @(posedge clk); #1; ro_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ro_rvalid !== 1'b0 || err !== 1'b0 || ro_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_state got rvalid=%b err=%b rdata=%h expected 0 0 0", ro_rvalid, err, ro_rdata);
    end
    @(posedge clk); #1; rst = 1'b0;
    run(rd(BASE), rd(BASE + 20));
    idle();
  endtask

  task automatic stall_access(input logic wen, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] exp);
    int n;
    @(posedge clk); #1;
    s_req = 1'b1; s_wen = wen; s_addr = a; s_be = 4'hF; s_wdata = d;
    n = 0;
    @(negedge clk);
    while (s_gnt !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL stall_gnt_cycle got=%0d expected=4", n + 1); end
    @(posedge clk); #1; s_req = 1'b0;
    @(negedge clk);
    checks++;
    if (s_rvalid !== 1'b1 || s_rdata !== exp) begin
      errors++;
      $display("FAIL stall_resp got rvalid=%b rdata=%h expected rvalid=1 rdata=%h", s_rvalid, s_rdata, exp);
    end
    @(negedge clk);
    checks++;
    if (s_rvalid !== 1'b0) begin errors++; $display("FAIL stall_rvalid_pulse got=%b expected=0", s_rvalid); end
  endtask

  task automatic test_stall();
    stall_access(1'b0, BASE + 40, 32'h1234_5678, 32'h0);
    stall_access(1'b1, BASE + 40, 32'h0, 32'h1234_5678);
    @(posedge clk); #1;
    s_req = 1'b1; s_wen = 1'b1; s_addr = BASE + 40;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (s_gnt !== 1'b0) begin errors++; $display("FAIL stall_early_gnt got=%b expected=0", s_gnt); end
    end
    @(posedge clk); #1; s_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (s_rvalid !== 1'b0 || s_gnt !== 1'b0) begin
        errors++;
        $display("FAIL stall_drop got rvalid=%b gnt=%b expected 0 0", s_rvalid, s_gnt);
      end
    end
    stall_access(1'b1, BASE + 40, 32'h0, 32'h1234_5678);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout bench did not finish, checks=%0d expected completion", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_back_to_back();
    test_same_word();
    test_oob();
    test_reset_mid();
    test_stall();
    repeat (3) @(negedge clk);
    checks++;
    if (ro_q.size() != 0 || wo_q.size() != 0) begin
      errors++;
      $display("FAIL missing_responses got ro=%0d wo=%0d outstanding expected 0 0", ro_q.size(), wo_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
